mux_rr_arbiter: RTL and testbench
=================================

Name: mux_rr_arbiter

Overview:
- Shares one registered output channel between N requesters.
- Each requester has a valid/ready/data channel; a round-robin arbiter drives the select of an N:1 data mux.
- The selected word is captured into a single output register with its own valid/ready handshake.
- Sits between several producers and one consumer, for example several traffic sources feeding one sink.

Parameters:
- WIDTH, 8, data width per requester and of the output.
- N, 4, number of requesters (N >= 2).
- IDW, $clog2(N), width of the grant index (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  N  bit k: requester k has a word.
- in_data  input  N*WIDTH  word of requester k at bits [k*WIDTH +: WIDTH].
- in_ready  output  N  bit k: word of requester k is accepted this cycle (one-hot or zero).
- out_valid  output  1  output register holds a word.
- out_data  output  WIDTH  word held in the output register.
- out_id  output  IDW  index of the requester whose word is in out_data.
- out_ready  input  1  consumer accepts out_data this cycle.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - out_valid=0, out_data=0, out_id=0.
  - Round-robin pointer last=N-1, so requester 0 has top priority first.
  - All in_ready=0 while in reset.
- State machine, two states:
  - EMPTY (out_valid=0) and FULL (out_valid=1). The state is out_valid itself.
- can_load = EMPTY | (FULL & out_ready).
- Winner selection (combinational):
  - Scan order is last+1, last+2, …, last+N, all modulo N.
  - The winner is the first index in that order with in_valid set.
  - No winner if in_valid == 0.
- in_ready[k] = can_load & (k == winner) & in_valid[k]. At most one bit is set.
  - in_ready may depend combinationally on in_valid and out_ready.
  - in_valid must never depend on in_ready.
- Transfer on requester k happens when in_valid[k] & in_ready[k]. On the next edge:
  - out_data <= in_data[k], out_id <= k, out_valid <= 1, last <= k.
- Drain: out_valid & out_ready with no new transfer in the same cycle → out_valid <= 0. out_data and out_id keep their old values.
- Simultaneous drain and load: the output register is reloaded and out_valid stays 1. Throughput is one word per cycle.
- Stall: out_valid=1 & out_ready=0 → out_valid, out_data and out_id hold stable, all in_ready=0, and last does not change.
- Latency: an accepted input appears on out_data exactly 1 cycle after the transfer edge.
- The pointer updates only on a transfer; idle cycles do not rotate priority.
- Fairness: with all N requesters continuously valid and out_ready=1, grant order is 0,1,…,N-1,0,… with no repeats.
- A requester that drops in_valid before being granted loses nothing; there is no request latching.
- Reset asserted mid-operation: any word held in the output register is discarded, out_valid drops immediately (asynchronously), and the pointer returns to N-1.
- Deassertion of rst_n is assumed to be synchronised upstream. The first grant is possible on the first edge after release.

Test Plan:
- Reset then release, all in_valid=0 → out_valid=0, in_ready=0000, out_data=0 for 5 cycles.
- in_valid=1111, data k = 8'hA0+k, out_ready=1 held → in_ready one-hot sequence 0001,0010,0100,1000,0001; out_data sequence A0,A1,A2,A3,A0, each 1 cycle after its grant; out_id follows 0,1,2,3,0.
- Only requester 2 valid (data 8'h5C), out_ready=0 → accepted on cycle 1. Then in_ready=0000 and out_data=5C/out_id=2 held for 4 stall cycles. Raise out_ready → drained; requester 2 is granted again the same cycle if still valid.
- Grant requester 1. Then in_valid=1011 → next grant goes to 3 (not 0 or 1). Then to 0, then to 1.
- Assert rst_n=0 mid-cycle while out_valid=1, out_data=A2 → out_valid=0 and out_data=0 immediately without waiting for a clock edge. After release, with all requesters valid, the first grant goes to requester 0.
- in_valid toggling 0101/1010 on alternate cycles with random out_ready (a bench model checks every accepted word) → no loss or duplication, out_id always matches the data source, and no requester waits more than N grants.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux_rr_arbiter
//
// Shares one registered output channel between N requesters. A round-robin
// arbiter picks one valid requester per cycle. Its word is captured into a
// single output register, which has its own valid/ready handshake.
//
// Handshake rule on every channel: a word moves on a rising edge where valid
// and ready are both high. A producer holds valid and its data until the word
// moves. valid never depends on ready. ready may depend on valid.
//
// Ports:
//   clk       in   1         rising-edge clock
//   rst_n     in   1         asynchronous active-low reset
//   in_valid  in   N         bit k: requester k offers a word
//   in_data   in   N*WIDTH   word of requester k at [k*WIDTH +: WIDTH]
//   in_ready  out  N         one-hot (or zero): requester k's word is taken
//   out_valid out  1         output register holds a word (also the FSM state)
//   out_data  out  WIDTH     word held in the output register
//   out_id    out  IDW       requester index the held word came from
//   out_ready in   1         consumer takes out_data this cycle
// ---------------------------------------------------------------------------
module mux_rr_arbiter #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int IDW   = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]     in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [IDW-1:0]   out_id,
    input  logic             out_ready
);

    // The FSM state is the occupancy of the output register. It is exposed
    // directly as out_valid.
    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_data;
    logic [IDW-1:0]   r_id;
    logic [IDW-1:0]   r_last;     // index of the most recent grant

    logic             w_can_load;
    logic             w_found;
    logic [IDW-1:0]   w_winner;
    logic             w_load;
    logic [WIDTH-1:0] w_sel_data;
    logic [N-1:0]     w_ready;

    // The register can take a word when it is empty. It can also take one
    // when it is being drained in this same cycle.
    assign w_can_load = (r_state == S_EMPTY) || out_ready;

    // Scan from the index after the last grant, wrapping around once. The
    // first valid index found wins. Priority rotates only when a grant is
    // taken, because r_last changes only then.
    always_comb begin
        int idx;
        w_found  = 1'b0;
        w_winner = '0;
        idx      = 0;
        for (int i = 1; i <= N; i++) begin
            idx = (int'(r_last) + i) % N;
            if (!w_found && in_valid[idx]) begin
                w_found  = 1'b1;
                w_winner = IDW'(idx);
            end
        end
    end

    // Winner already implies in_valid[winner], so no further gating is needed.
    assign w_load = w_found && w_can_load && rst_n;

    // N:1 data mux steered by the winner index.
    always_comb begin
        w_sel_data = '0;
        for (int k = 0; k < N; k++) begin
            if (w_winner == IDW'(k)) begin
                w_sel_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        w_ready = '0;
        if (w_load) begin
            w_ready[w_winner] = 1'b1;
        end
    end

    assign in_ready = w_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
            r_data  <= '0;
            r_id    <= '0;
            r_last  <= IDW'(N - 1);   // requester 0 is scanned first
        end else begin
            if (w_load) begin
                // A load covers the case of a drain and a reload together.
                r_state <= S_FULL;
                r_data  <= w_sel_data;
                r_id    <= w_winner;
                r_last  <= w_winner;
            end else if (r_state == S_FULL && out_ready) begin
                // Drain only. The data and id stay as they were.
                r_state <= S_EMPTY;
            end
        end
    end

    assign out_valid = (r_state == S_FULL);
    assign out_data  = r_data;
    assign out_id    = r_id;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for mux_rr_arbiter (WIDTH=8, N=4).
// The reference model keeps the output register contents and the last-granted
// index as plain variables. It picks each winner by scanning indices modulo N.
// A queue holds the words that have been accepted and not yet consumed.
// ---------------------------------------------------------------------------
module tb_mux_rr_arbiter;

    localparam int WIDTH = 8;
    localparam int N     = 4;
    localparam int IDW   = $clog2(N);

    logic                 clk;
    logic                 rst_n;
    logic [N-1:0]         in_valid;
    logic [N*WIDTH-1:0]   in_data;
    logic [N-1:0]         in_ready;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_data;
    logic [IDW-1:0]       out_id;
    logic                 out_ready;

    mux_rr_arbiter #(.WIDTH(WIDTH), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [WIDTH-1:0]     data_arr [N];
    logic                 m_valid;
    logic [WIDTH-1:0]     m_data;
    logic [IDW-1:0]       m_id;
    int                   m_last;
    int                   wait_cnt [N];
    logic [N-1:0]         obs_rdy;
    logic [IDW+WIDTH-1:0] exp_q [$];

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_id    = '0;
        m_last  = N - 1;
        exp_q.delete();
        for (int k = 0; k < N; k++) wait_cnt[k] = 0;
    endtask

    function automatic int model_winner(input logic [N-1:0] v);
        for (int i = 1; i <= N; i++) begin
            if (v[(m_last + i) % N]) return (m_last + i) % N;
        end
        return -1;
    endfunction

    // One clock cycle: drive inputs after the falling edge and check the
    // combinational ready. Then take the rising edge, update the model and
    // check the registered outputs.
    task automatic step(input logic [N-1:0] v, input logic ordy);
        int win;
        logic [N-1:0] exp_rdy;
        logic [IDW+WIDTH-1:0] w;
        @(negedge clk);
        in_valid  = v;
        out_ready = ordy;
        for (int k = 0; k < N; k++) in_data[k*WIDTH +: WIDTH] = data_arr[k];
        #1;
        win     = model_winner(v);
        exp_rdy = '0;
        if (win >= 0 && (!m_valid || ordy)) exp_rdy[win] = 1'b1;
        obs_rdy = in_ready;
        check("in_ready", in_ready, exp_rdy);
        // Consumer side of the scoreboard.
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_word", 1, 0);
            end else begin
                w = exp_q.pop_front();
                check("sb_word", {out_id, out_data}, w);
            end
        end
        @(posedge clk);
        if (exp_rdy != '0) begin
            exp_q.push_back({IDW'(win), data_arr[win]});
            for (int k = 0; k < N; k++) begin
                if (k == win || !v[k]) wait_cnt[k] = 0;
                else                   wait_cnt[k]++;
                check("starvation", wait_cnt[k] < N, 1);
            end
            m_valid = 1'b1;
            m_data  = data_arr[win];
            m_id    = IDW'(win);
            m_last  = win;
        end else if (m_valid && ordy) begin
            m_valid = 1'b0;
        end
        #1;
        check("out_valid", out_valid, m_valid);
        check("out_data", out_data, m_data);
        check("out_id", out_id, m_id);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n     = 1'b0;
        in_valid  = '1;
        in_data   = '0;
        out_ready = 1'b0;
        for (int k = 0; k < N; k++) data_arr[k] = '0;
        model_reset();

        // Reset: nothing is granted while reset is held, even with requests.
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_id", out_id, 0);
        @(negedge clk);
        in_valid = '0;
        rst_n    = 1'b1;

        // Idle after release.
        for (int i = 0; i < 5; i++) begin
            step(4'b0000, 1'b1);
            check("idle_ready", obs_rdy, 0);
        end

        // Fairness with all requesters valid.
        for (int k = 0; k < N; k++) data_arr[k] = 8'hA0 + 8'(k);
        for (int i = 0; i < 5; i++) begin
            step(4'b1111, 1'b1);
            check("fair_grant", obs_rdy, 4'b0001 << (i % N));
            check("fair_data", out_data, 8'hA0 + 8'(i % N));
            check("fair_id", out_id, i % N);
        end
        step(4'b0000, 1'b1);   // drain

        // Stall with a single requester.
        data_arr[2] = 8'h5C;
        step(4'b0100, 1'b0);
        check("stall_accept", obs_rdy, 4'b0100);
        for (int i = 0; i < 4; i++) begin
            step(4'b0100, 1'b0);
            check("stall_ready", obs_rdy, 0);
            check("stall_data", out_data, 8'h5C);
            check("stall_id", out_id, 2);
        end
        step(4'b0100, 1'b1);
        check("drain_regrant", obs_rdy, 4'b0100);
        step(4'b0000, 1'b1);

        // Rotation past a lower-index requester.
        step(4'b0010, 1'b1);
        check("rot_g1", obs_rdy, 4'b0010);
        step(4'b1011, 1'b1);
        check("rot_g3", obs_rdy, 4'b1000);
        step(4'b1011, 1'b1);
        check("rot_g0", obs_rdy, 4'b0001);
        step(4'b1011, 1'b1);
        check("rot_g1b", obs_rdy, 4'b0010);
        step(4'b0000, 1'b1);

        // Asynchronous reset while the register holds A2.
        @(negedge clk);
        in_valid = '0;
        rst_n    = 1'b0;
        @(negedge clk);
        in_valid = '0;
        rst_n    = 1'b1;
        model_reset();
        for (int k = 0; k < N; k++) data_arr[k] = 8'hA0 + 8'(k);
        for (int i = 0; i < 3; i++) step(4'b1111, 1'b1);
        check("pre_rst_data", out_data, 8'hA2);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_out_valid", out_valid, 0);
        check("async_out_data", out_data, 0);
        check("async_in_ready", in_ready, 0);
        model_reset();
        @(negedge clk);
        in_valid = '0;
        rst_n    = 1'b1;
        step(4'b1111, 1'b1);
        check("post_rst_grant", obs_rdy, 4'b0001);

        // Random: alternating request patterns, random data and back-pressure.
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < N; k++) data_arr[k] = WIDTH'($urandom_range(0, 255));
            step((i % 2 == 0) ? 4'b0101 : 4'b1010, 1'($urandom_range(0, 1)));
        end
        // Random: arbitrary request patterns.
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < N; k++) data_arr[k] = WIDTH'($urandom_range(0, 255));
            step(N'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0));
        end
        // Drain whatever is left so the scoreboard sees it.
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        check("sb_empty_at_end", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
